// File: rtl/rs_pkg.sv
// Shared definitions for the ALU reservation station, its decoder and the ALU.
//   - default widths of the station configuration
//   - TAG_FREE: tag value meaning "operand already holds its value"
//   - bit offsets of the packed op word {dest, tag2, data2, tag1, data1, op}
//   - rs_entry_t: one station entry at the default widths
package rs_pkg;

    localparam int RS_ENTRIES = 8;
    localparam int RS_DATA_W  = 32;
    localparam int RS_TAG_W   = 4;
    localparam int RS_OP_W    = 5;

    // Tags are {1'b0, rob_index}; the MSB set marks a value that is present.
    localparam logic [RS_TAG_W-1:0] TAG_FREE = {1'b1, {(RS_TAG_W-1){1'b0}}};

    // Field offsets of the packed op word, op at bit 0.
    function automatic int f_data1_lsb(int op_w);
        return op_w;
    endfunction

    function automatic int f_tag1_lsb(int op_w, int data_w);
        return op_w + data_w;
    endfunction

    function automatic int f_data2_lsb(int op_w, int data_w, int tag_w);
        return op_w + data_w + tag_w;
    endfunction

    function automatic int f_tag2_lsb(int op_w, int data_w, int tag_w);
        return op_w + 2*data_w + tag_w;
    endfunction

    function automatic int f_dest_lsb(int op_w, int data_w, int tag_w);
        return op_w + 2*data_w + 2*tag_w;
    endfunction

    function automatic int f_in_w(int op_w, int data_w, int tag_w);
        return op_w + 2*data_w + 2*tag_w + (tag_w - 1);
    endfunction

    typedef struct packed {
        logic                  busy;
        logic [RS_OP_W-1:0]    op;
        logic [RS_TAG_W-2:0]   dest;
        logic [RS_TAG_W-1:0]   tag1;
        logic [RS_DATA_W-1:0]  data1;
        logic [RS_TAG_W-1:0]   tag2;
        logic [RS_DATA_W-1:0]  data2;
    } rs_entry_t;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index-first priority encoder.
//   req : N request bits
//   gnt : one-hot grant of the lowest set request (zero when none)
//   idx : binary index of the grant (zero when none)
//   any : at least one request is set
module rs_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = |req;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N-1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = ($clog2(N))'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// Reservation station in front of the integer ALU.
// Holds up to ENTRIES decoded ops, wakes pending operands by snooping the CDB
// and issues the lowest-index ready op to the ALU.
//   clk, rst (async, active low)
//   in_valid/in_data   : op from the decoder {dest, tag2, data2, tag1, data1, op}
//   rs_full            : no free entry, decode must stall
//   cdb_valid/tag/data : result broadcast
//   issue_valid/ready  : handshake to the ALU, issue_op/a/b/dest payload
//   flush              : synchronous clear of every entry
module alu_rs
    import rs_pkg::*;
#(
    parameter int ENTRIES = RS_ENTRIES,
    parameter int DATA_W  = RS_DATA_W,
    parameter int TAG_W   = RS_TAG_W,
    parameter int OP_W    = RS_OP_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    input  logic [f_in_w(OP_W, DATA_W, TAG_W)-1:0] in_data,
    output logic                                  rs_full,
    input  logic                                  cdb_valid,
    input  logic [TAG_W-1:0]                      cdb_tag,
    input  logic [DATA_W-1:0]                     cdb_data,
    output logic                                  issue_valid,
    input  logic                                  issue_ready,
    output logic [OP_W-1:0]                       issue_op,
    output logic [DATA_W-1:0]                     issue_a,
    output logic [DATA_W-1:0]                     issue_b,
    output logic [TAG_W-2:0]                      issue_dest,
    input  logic                                  flush
);

    localparam int IDX_W     = $clog2(ENTRIES);
    localparam int D1_LSB    = f_data1_lsb(OP_W);
    localparam int T1_LSB    = f_tag1_lsb(OP_W, DATA_W);
    localparam int D2_LSB    = f_data2_lsb(OP_W, DATA_W, TAG_W);
    localparam int T2_LSB    = f_tag2_lsb(OP_W, DATA_W, TAG_W);
    localparam int DEST_LSB  = f_dest_lsb(OP_W, DATA_W, TAG_W);
    localparam logic [TAG_W-1:0] FREE_TAG = {1'b1, {(TAG_W-1){1'b0}}};

    logic [ENTRIES-1:0] busy_q;
    logic [OP_W-1:0]    op_q    [ENTRIES];
    logic [TAG_W-2:0]   dest_q  [ENTRIES];
    logic [TAG_W-1:0]   tag1_q  [ENTRIES];
    logic [DATA_W-1:0]  data1_q [ENTRIES];
    logic [TAG_W-1:0]   tag2_q  [ENTRIES];
    logic [DATA_W-1:0]  data2_q [ENTRIES];

    logic [OP_W-1:0]    in_op;
    logic [TAG_W-2:0]   in_dest;
    logic [TAG_W-1:0]   in_tag1, in_tag2;
    logic [DATA_W-1:0]  in_data1, in_data2;
    logic               in_hit1, in_hit2;

    assign in_op    = in_data[0 +: OP_W];
    assign in_data1 = in_data[D1_LSB +: DATA_W];
    assign in_tag1  = in_data[T1_LSB +: TAG_W];
    assign in_data2 = in_data[D2_LSB +: DATA_W];
    assign in_tag2  = in_data[T2_LSB +: TAG_W];
    assign in_dest  = in_data[DEST_LSB +: TAG_W-1];

    // Result broadcast in the allocation cycle would otherwise be missed.
    assign in_hit1 = cdb_valid && (in_tag1 != FREE_TAG) && (in_tag1 == cdb_tag);
    assign in_hit2 = cdb_valid && (in_tag2 != FREE_TAG) && (in_tag2 == cdb_tag);

    logic [ENTRIES-1:0] free_req, free_gnt;
    logic [IDX_W-1:0]   free_idx;
    logic               free_any;
    logic [ENTRIES-1:0] rdy_req, rdy_gnt;
    logic [IDX_W-1:0]   rdy_idx;
    logic               rdy_any;

    assign free_req = ~busy_q;

    always_comb begin
        rdy_req = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            rdy_req[i] = busy_q[i] && (tag1_q[i] == FREE_TAG) && (tag2_q[i] == FREE_TAG);
        end
    end

    rs_prio_enc #(.N(ENTRIES)) u_free_sel (
        .req (free_req),
        .gnt (free_gnt),
        .idx (free_idx),
        .any (free_any)
    );

    rs_prio_enc #(.N(ENTRIES)) u_rdy_sel (
        .req (rdy_req),
        .gnt (rdy_gnt),
        .idx (rdy_idx),
        .any (rdy_any)
    );

    logic               alloc_fire, issue_fire;
    logic [ENTRIES-1:0] alloc_mask, issue_mask;

    assign rs_full    = ~free_any;
    assign alloc_fire = in_valid && free_any;
    assign issue_fire = rdy_any && issue_ready;
    assign alloc_mask = alloc_fire ? free_gnt : '0;
    assign issue_mask = issue_fire ? rdy_gnt : '0;

    // Allocation only targets slots free at the start of the cycle, so a slot
    // released by this cycle's issue stays empty until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else if (flush) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q | alloc_mask) & ~issue_mask;
        end
    end

    // Payload carries no reset: it is only observed through busy entries.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (cdb_valid && busy_q[i]) begin
                if ((tag1_q[i] != FREE_TAG) && (tag1_q[i] == cdb_tag)) begin
                    tag1_q[i]  <= FREE_TAG;
                    data1_q[i] <= cdb_data;
                end
                if ((tag2_q[i] != FREE_TAG) && (tag2_q[i] == cdb_tag)) begin
                    tag2_q[i]  <= FREE_TAG;
                    data2_q[i] <= cdb_data;
                end
            end
        end
        if (alloc_fire) begin
            op_q[free_idx]    <= in_op;
            dest_q[free_idx]  <= in_dest;
            tag1_q[free_idx]  <= in_hit1 ? FREE_TAG : in_tag1;
            data1_q[free_idx] <= in_hit1 ? cdb_data : in_data1;
            tag2_q[free_idx]  <= in_hit2 ? FREE_TAG : in_tag2;
            data2_q[free_idx] <= in_hit2 ? cdb_data : in_data2;
        end
    end

    // Zeroed when idle so the ALU never sees unwritten payload.
    assign issue_valid = rdy_any;
    assign issue_op    = rdy_any ? op_q[rdy_idx]    : '0;
    assign issue_a     = rdy_any ? data1_q[rdy_idx] : '0;
    assign issue_b     = rdy_any ? data2_q[rdy_idx] : '0;
    assign issue_dest  = rdy_any ? dest_q[rdy_idx]  : '0;

endmodule

// File: tb/tb_alu_rs.sv
module tb_alu_rs;
    import rs_pkg::*;

    localparam int ENTRIES = 8;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 4;
    localparam int OP_W    = 5;
    localparam int IN_W    = (TAG_W-1) + 2*TAG_W + 2*DATA_W + OP_W;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [IN_W-1:0]   in_data;
    logic              rs_full;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              issue_valid;
    logic              issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [DATA_W-1:0] issue_a;
    logic [DATA_W-1:0] issue_b;
    logic [TAG_W-2:0]  issue_dest;
    logic              flush;

    alu_rs #(.ENTRIES(ENTRIES), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .rs_full     (rs_full),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_a     (issue_a),
        .issue_b     (issue_b),
        .issue_dest  (issue_dest),
        .flush       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain table of the entries the station should hold.
    localparam logic [TAG_W-1:0] FREE = 4'b1000;
    rs_entry_t mdl [ENTRIES];

    logic [OP_W-1:0]   s_op;
    logic [TAG_W-2:0]  s_dest;
    logic [TAG_W-1:0]  s_t1, s_t2;
    logic [DATA_W-1:0] s_d1, s_d2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int model_pick();
        for (int i = 0; i < ENTRIES; i++)
            if (mdl[i].busy && mdl[i].tag1 == FREE && mdl[i].tag2 == FREE) return i;
        return -1;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < ENTRIES; i++) if (mdl[i].busy) n++;
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) mdl[i].busy = 1'b0;
    endtask

    task automatic set_in(input bit v, input logic [OP_W-1:0] op, input logic [TAG_W-2:0] dest,
                          input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] d1,
                          input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] d2);
        s_op = op; s_dest = dest; s_t1 = t1; s_d1 = d1; s_t2 = t2; s_d2 = d2;
        in_data  = {dest, t2, d2, t1, d1, op};
        in_valid = v;
    endtask

    task automatic check_outputs();
        int p;
        p = model_pick();
        check("issue_valid", 64'(issue_valid), 64'(p >= 0));
        check("rs_full", 64'(rs_full), 64'(model_count() == ENTRIES));
        if (p >= 0) begin
            check("issue_op", 64'(issue_op), 64'(mdl[p].op));
            check("issue_a", 64'(issue_a), 64'(mdl[p].data1));
            check("issue_b", 64'(issue_b), 64'(mdl[p].data2));
            check("issue_dest", 64'(issue_dest), 64'(mdl[p].dest));
        end else begin
            check("idle_known", 64'($isunknown({issue_op, issue_a, issue_b, issue_dest})), 64'(0));
        end
        if (in_valid) check("alloc_while_full", 64'(rs_full), 64'(0));
    endtask

    task automatic model_update();
        int p;
        int f;
        p = model_pick();
        f = -1;
        if (flush) begin
            model_clear();
        end else begin
            for (int i = ENTRIES-1; i >= 0; i--) if (!mdl[i].busy) f = i;
            for (int i = 0; i < ENTRIES; i++) begin
                if (mdl[i].busy && cdb_valid) begin
                    if (mdl[i].tag1 != FREE && mdl[i].tag1 == cdb_tag) begin
                        mdl[i].tag1 = FREE; mdl[i].data1 = cdb_data;
                    end
                    if (mdl[i].tag2 != FREE && mdl[i].tag2 == cdb_tag) begin
                        mdl[i].tag2 = FREE; mdl[i].data2 = cdb_data;
                    end
                end
            end
            if (in_valid && f >= 0) begin
                mdl[f].busy  = 1'b1;
                mdl[f].op    = s_op;
                mdl[f].dest  = s_dest;
                mdl[f].tag1  = s_t1;
                mdl[f].data1 = s_d1;
                mdl[f].tag2  = s_t2;
                mdl[f].data2 = s_d2;
                if (cdb_valid && s_t1 != FREE && s_t1 == cdb_tag) begin
                    mdl[f].tag1 = FREE; mdl[f].data1 = cdb_data;
                end
                if (cdb_valid && s_t2 != FREE && s_t2 == cdb_tag) begin
                    mdl[f].tag2 = FREE; mdl[f].data2 = cdb_data;
                end
            end
            if (p >= 0 && issue_ready) mdl[p].busy = 1'b0;
        end
    endtask

    // One clock: check outputs of the current cycle, advance the model, cross the edge.
    task automatic step();
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        set_in(1'b0, '0, '0, FREE, '0, FREE, '0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; issue_ready = 1'b0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        idle_in();
        model_clear();
        #3;
        check("reset_valid", 64'(issue_valid), 64'(0));
        check("reset_full", 64'(rs_full), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;

        // Both operands present: issue one cycle after allocation.
        issue_ready = 1'b1;
        set_in(1'b1, 5'd1, 3'd3, FREE, 32'd5, FREE, 32'd7);
        step();
        idle_in();
        check("ready_valid", 64'(issue_valid), 64'(1));
        check("ready_a", 64'(issue_a), 64'(5));
        check("ready_b", 64'(issue_b), 64'(7));
        check("ready_dest", 64'(issue_dest), 64'(3));
        step();
        check("ready_drained", 64'(issue_valid), 64'(0));

        // Wakeup through the CDB two cycles after allocation.
        set_in(1'b1, 5'd2, 3'd1, 4'b0010, 32'h1111, FREE, 32'h22);
        step();
        idle_in();
        check("wake_wait1", 64'(issue_valid), 64'(0));
        step();
        check("wake_wait2", 64'(issue_valid), 64'(0));
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'hDEAD;
        step();
        cdb_valid = 1'b0;
        check("wake_valid", 64'(issue_valid), 64'(1));
        check("wake_a", 64'(issue_a), 64'hDEAD);
        check("wake_b", 64'(issue_b), 64'h22);
        step();

        // Broadcast in the allocation cycle.
        set_in(1'b1, 5'd3, 3'd5, FREE, 32'd1, 4'd5, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'd9;
        step();
        idle_in();
        cdb_valid = 1'b0;
        check("bypass_valid", 64'(issue_valid), 64'(1));
        check("bypass_b", 64'(issue_b), 64'd9);
        step();

        // Fill every slot with pending ops.
        issue_ready = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            set_in(1'b1, 5'(i), 3'(i), 4'(i), 32'(100 + i), FREE, 32'(200 + i));
            step();
        end
        idle_in();
        check("fill_full", 64'(rs_full), 64'(1));
        check("fill_idle", 64'(issue_valid), 64'(0));
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 32'h66;
        step();
        cdb_tag = 4'd3; cdb_data = 32'h33;
        step();
        cdb_valid = 1'b0;
        check("lowest_dest", 64'(issue_dest), 64'd3);

        // Stall the ALU for three cycles: payload must hold.
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_valid", 64'(issue_valid), 64'(1));
            check("stall_dest", 64'(issue_dest), 64'd3);
            check("stall_a", 64'(issue_a), 64'h33);
            check("stall_b", 64'(issue_b), 64'd203);
            check("stall_full", 64'(rs_full), 64'(1));
        end
        issue_ready = 1'b1;
        step();
        check("release_full", 64'(rs_full), 64'(0));
        check("release_next", 64'(issue_dest), 64'd6);
        issue_ready = 1'b0;

        // Flush with allocation attempted in the same cycle.
        flush = 1'b1;
        set_in(1'b1, 5'd9, 3'd2, FREE, 32'd1, FREE, 32'd2);
        step();
        flush = 1'b0;
        idle_in();
        check("flush_full", 64'(rs_full), 64'(0));
        check("flush_valid", 64'(issue_valid), 64'(0));
        step();

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            issue_ready = ($urandom_range(0, 3) != 0);
            cdb_valid   = ($urandom_range(0, 1) != 0);
            cdb_tag     = 4'($urandom_range(0, 7));
            cdb_data    = $urandom;
            flush       = ($urandom_range(0, 63) == 0);
            if (model_count() < ENTRIES && $urandom_range(0, 2) != 0)
                set_in(1'b1, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                       ($urandom_range(0, 1) != 0) ? FREE : 4'($urandom_range(0, 7)), $urandom,
                       ($urandom_range(0, 1) != 0) ? FREE : 4'($urandom_range(0, 7)), $urandom);
            else
                idle_in();
            step();
        end

        // Asynchronous reset in the middle of activity.
        flush = 1'b0; cdb_valid = 1'b0; issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 5'(i), 3'(i), FREE, 32'(i), FREE, 32'(i));
            step();
        end
        idle_in();
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 64'(issue_valid), 64'(0));
        check("async_rst_full", 64'(rs_full), 64'(0));
        model_clear();
        @(posedge clk); #1;
        rst = 1'b1;
        issue_ready = 1'b1;
        set_in(1'b1, 5'd7, 3'd4, FREE, 32'hAB, FREE, 32'hCD);
        step();
        idle_in();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
